// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the register-file family: sweep FSM state encoding and depth helper.
package regfile_mp_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic int unsigned rf_depth(input int unsigned regbits);
        return 32'd1 << regbits;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: one write port, NREAD packed read ports.
interface regfile_mp_if #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int NREAD   = 2
);
    logic                     regwrite;
    logic [REGBITS-1:0]       wa;
    logic [WIDTH-1:0]         wd;
    logic [NREAD*REGBITS-1:0] ra;
    logic [NREAD*WIDTH-1:0]   rd;
    logic                     busy;

    modport master (output regwrite, wa, wd, ra, input rd, busy);
    modport slave  (input regwrite, wa, wd, ra, output rd, busy);
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sweep: walks every entry once, one per cycle, and flags busy until done.
module regfile_clear_seq
    import regfile_mp_pkg::*;
#(
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               busy,
    output logic               clr_we,
    output logic [REGBITS-1:0] clr_addr
);
    localparam int unsigned    DEPTH = rf_depth(REGBITS);
    // One extra pointer bit keeps the end-of-sweep compare free of wrap-around.
    localparam logic [REGBITS:0] LAST = (REGBITS + 1)'(DEPTH - 1);

    rf_state_e          state_q, state_d;
    logic [REGBITS:0]   ptr_q, ptr_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        if (state_q == RF_CLEAR) begin
            clr_we = !reset;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_q == LAST) state_d = RF_READY;
        end
    end

    assign busy     = (state_q == RF_CLEAR);
    assign clr_addr = ptr_q[REGBITS-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational reads, one synchronous write, optional zero R0,
// write-to-read bypass and a self-clearing sweep after every reset.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter int NREAD   = 2,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = rf_depth(REGBITS);

    logic [WIDTH-1:0]   ram [DEPTH];
    logic               busy;
    logic               clr_we;
    logic [REGBITS-1:0] clr_addr;
    logic               we;
    logic [REGBITS-1:0] waddr;
    logic [WIDTH-1:0]   wdata;
    logic               user_we;

    regfile_clear_seq #(.REGBITS(REGBITS)) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.busy = busy;

    // The sweep owns the write port while busy; user writes to a hardwired R0 are dropped.
    assign user_we = !busy && bus.regwrite && !((ZERO_R0 != 0) && (bus.wa == '0));
    assign we      = clr_we || user_we;
    assign waddr   = clr_we ? clr_addr : bus.wa;
    assign wdata   = clr_we ? '0 : bus.wd;

    // NOTE: the storage array has no reset branch so it maps to distributed RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [REGBITS-1:0] ra_g;
        logic [WIDTH-1:0]   rd_g;

        assign ra_g = bus.ra[g*REGBITS +: REGBITS];

        always_comb begin
            rd_g = ram[ra_g];
            if (busy || ((ZERO_R0 != 0) && (ra_g == '0))) begin
                rd_g = '0;
            end else if ((BYPASS != 0) && bus.regwrite && (ra_g == bus.wa)) begin
                rd_g = bus.wd;
            end
        end

        assign bus.rd[g*WIDTH +: WIDTH] = rd_g;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: sweep timing, read gating, bypass on/off, zero R0, multi-port reads.
module tb_regfile_mp;

    logic clk;
    logic reset_a;
    logic reset_b;

    regfile_mp_if #(.WIDTH(16), .REGBITS(4), .NREAD(4)) bus_a ();
    regfile_mp_if #(.WIDTH(16), .REGBITS(4), .NREAD(2)) bus_b ();

    regfile_mp #(.WIDTH(16), .REGBITS(4), .NREAD(4), .ZERO_R0(1), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    regfile_mp #(.WIDTH(16), .REGBITS(4), .NREAD(2), .ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic             we;
        logic [3:0]       wa;
        logic [15:0]      wd;
        logic [3:0][3:0]  ra;
        logic [3:0][15:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                                input logic [3:0] r0, input logic [3:0] r1,
                                input logic [3:0] r2, input logic [3:0] r3,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.rd[0] = e0; v.rd[1] = e1; v.rd[2] = e2; v.rd[3] = e3;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_a(input logic [3:0] wa, input logic [15:0] wd);
        bus_a.regwrite = 1'b1;
        bus_a.wa       = wa;
        bus_a.wd       = wd;
        step();
        bus_a.regwrite = 1'b0;
    endtask

    // Called right after the reset edge: busy must hold for 16 cycles, then drop.
    task automatic sweep_busy_a(input string tag);
        for (int c = 0; c < 16; c++) begin
            check($sformatf("%s_busy%0d", tag, c), 64'(bus_a.busy), 64'd1);
            step();
        end
        check($sformatf("%s_ready", tag), 64'(bus_a.busy), 64'd0);
    endtask

    task automatic all_zero_a(input string tag);
        for (int a = 0; a < 16; a++) begin
            bus_a.ra = {4{4'(a)}};
            #1;
            check($sformatf("%s_addr%0d", tag, a), 64'(bus_a.rd), 64'd0);
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = mk(1, 4'd1,  16'h0011, 1, 0, 0, 0,  16'h0011, 0, 0, 0);
        vecs[1] = mk(1, 4'd2,  16'h0022, 1, 2, 0, 0,  16'h0011, 16'h0022, 0, 0);
        vecs[2] = mk(1, 4'd15, 16'h00FF, 15, 2, 1, 0, 16'h00FF, 16'h0022, 16'h0011, 0);
        vecs[3] = mk(0, 4'd0,  16'h0000, 1, 2, 1, 15, 16'h0011, 16'h0022, 16'h0011, 16'h00FF);
        vecs[4] = mk(1, 4'd5,  16'hBEEF, 5, 1, 0, 5,  16'hBEEF, 16'h0011, 0, 16'hBEEF);
        vecs[5] = mk(0, 4'd0,  16'h0000, 5, 5, 5, 5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF);
        vecs[6] = mk(1, 4'd0,  16'hAAAA, 0, 5, 0, 0,  0, 16'hBEEF, 0, 0);
        vecs[7] = mk(0, 4'd0,  16'h0000, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[8] = mk(1, 4'd5,  16'h1357, 5, 15, 0, 2, 16'h1357, 16'h00FF, 0, 16'h0022);
        vecs[9] = mk(0, 4'd0,  16'h0000, 5, 4, 3, 2,  16'h1357, 0, 0, 16'h0022);

        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.regwrite = 1'b0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra = '0;
        bus_b.regwrite = 1'b0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra = '0;
        step();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Sweep length after a one-cycle reset, reads gated while busy, all entries cleared.
        check("t1_rd_while_busy", 64'(bus_a.rd), 64'd0);
        sweep_busy_a("t1");
        check("t1_b_ready", 64'(bus_b.busy), 64'd0);
        all_zero_a("t1_clear");

        // Fill with ones, reset, and hammer a write to 3 through the whole sweep.
        for (int a = 1; a < 16; a++) write_a(4'(a), 16'hFFFF);
        bus_a.ra = {4{4'd7}};
        #1;
        check("t2_preload", 64'(bus_a.rd[15:0]), 64'hFFFF);
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        bus_a.regwrite = 1'b1;
        bus_a.wa       = 4'd3;
        bus_a.wd       = 16'h1234;
        bus_a.ra       = {4'd1, 4'd15, 4'd3, 4'd10};
        for (int c = 0; c < 16; c++) begin
            #1;
            check($sformatf("t2_busy%0d", c), 64'(bus_a.busy), 64'd1);
            check($sformatf("t2_rd%0d", c), 64'(bus_a.rd), 64'd0);
            step();
        end
        bus_a.regwrite = 1'b0;
        check("t2_ready", 64'(bus_a.busy), 64'd0);
        all_zero_a("t2_clear");

        // Table: bypass, zero R0, multi-port reads on the 4-port bypassing instance.
        for (int i = 0; i < 10; i++) begin
            bus_a.regwrite = vecs[i].we;
            bus_a.wa       = vecs[i].wa;
            bus_a.wd       = vecs[i].wd;
            bus_a.ra       = vecs[i].ra;
            #1;
            for (int p = 0; p < 4; p++)
                check($sformatf("vec%0d_rd%0d", i, p), 64'(bus_a.rd[p*16 +: 16]), 64'(vecs[i].rd[p]));
            step();
        end
        bus_a.regwrite = 1'b0;

        // Without bypass the written value shows up one cycle later.
        bus_b.regwrite = 1'b1;
        bus_b.wa       = 4'd5;
        bus_b.wd       = 16'hBEEF;
        bus_b.ra       = {4'd0, 4'd5};
        #1;
        check("t3_nobypass_same", 64'(bus_b.rd[15:0]), 64'h0000);
        step();
        bus_b.regwrite = 1'b0;
        #1;
        check("t3_nobypass_next", 64'(bus_b.rd[15:0]), 64'hBEEF);
        check("t3_nobypass_r0", 64'(bus_b.rd[31:16]), 64'h0000);

        // Reset mid-sweep restarts the full sweep and wipes earlier writes.
        write_a(4'd9, 16'h0999);
        bus_a.ra = {4{4'd9}};
        #1;
        check("t5_pre", 64'(bus_a.rd[15:0]), 64'h0999);
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("t5_first_busy%0d", c), 64'(bus_a.busy), 64'd1);
            step();
        end
        reset_a = 1'b1;
        step();
        reset_a = 1'b0;
        sweep_busy_a("t5");
        bus_a.ra = {4{4'd9}};
        #1;
        check("t5_cleared9", 64'(bus_a.rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
